fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end for the LEGv8 core. It sits directly upstream of the decode/execute datapath and owns the program counter. It issues in-order word requests to a variable-latency instruction memory and buffers returned instructions with their PCs in a small queue. It delivers them to decode over a valid/ready handshake and handles branch redirects by flushing the queue and discarding in-flight responses.

## Interface
- DEPTH, 4, queue entries and maximum in-flight-plus-buffered instructions; power of two, ≥2
- CLK  in  1  clock, all state updates on rising edge
- resetl  in  1  reset, asynchronous, active-low
- startpc  in  64  boot PC, sampled in BOOT state
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  64  fetch address, word aligned
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction word returned (in order, always accepted)
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_data  out  32  instruction at queue head
- inst_pc  out  64  PC of inst_data
- inst_ready  in  1  decode consumes head
- redirect_valid  in  1  branch taken / PC override, single-cycle pulse
- redirect_pc  in  64  new fetch PC; bits [1:0] forced to 0
- stall_cycles  out  32  only with FETCH_PERF_CNT_EN

## Operation
- States: BOOT, RUN, DRAIN. Reset enters BOOT; fpc, rpc, outstanding, drop_cnt, queue count = 0.
- BOOT (one cycle): fpc and rpc ← startpc; next state RUN. A redirect in BOOT wins over startpc.
- RUN: imem_req_valid = (outstanding + count < DEPTH); imem_req_addr = fpc. Request fires on valid && ready; fpc += 4, outstanding += 1.
- Response: outstanding −= 1. In RUN, push {rpc, imem_resp_data} and rpc += 4. In DRAIN, discard and drop_cnt −= 1.
- Pop on inst_valid && inst_ready.
- Redirect (any state): flush queue; fpc and rpc ← {redirect_pc[63:2], 2'b00}; drop_cnt ← outstanding + req_fire − resp_fire. Next state is DRAIN if that value ≠ 0, else RUN.
- A response arriving in the redirect cycle is discarded. A request firing in the redirect cycle uses the old fpc and is counted in drop_cnt.
- A pop coinciding with a redirect completes: decode owns that instruction. Redirect squashing is decode's responsibility.
- DRAIN: imem_req_valid = 0. On drop_cnt reaching 0 → RUN. A further redirect in DRAIN recomputes drop_cnt as above.
- Memory samples the address only on valid && ready. Request withdrawal or address change while ready is low is legal only on redirect.
- Arithmetic: PC increments are modulo 2^64. outstanding and count are $clog2(DEPTH+1) bits. outstanding + count ≤ DEPTH always holds.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr 0, inst_valid 0, inst_data 0, inst_pc 0, stall_cycles 0.
- Reset deassert → BOOT cycle → first request possible on the following cycle.
- Response accepted at edge N → inst_valid high after edge N (registered queue, 1-cycle latency).
- Zero-wait memory with inst_ready held high: one instruction per cycle sustained.
- Full (count == DEPTH): inst_valid held, no requests. Empty: inst_valid 0.
- Redirect: queue empty after that edge; first new request issued the same cycle the state becomes RUN.
- Asynchronous reset mid-fetch abandons in-flight requests. The memory must also be reset.

## Configuration
- FETCH_PERF_CNT_EN defined: stall_cycles port present. It counts cycles in RUN with inst_ready high and inst_valid low, saturates at 2^32−1, and is cleared by reset.
- Undefined: port and counter absent; no other behaviour change.

## Structure
- fetch_pkg: state enum (BOOT, RUN, DRAIN), INST_W = 32, PC_W = 64, PC_INC = 4.
- Sub-module fetch_queue: synchronous FIFO of {pc, inst} with push, pop, flush, count. Flush has priority over push and pop.

## Test plan
- Reset then startpc = 0x400, zero-wait memory, inst_ready = 1 → requests 0x400, 0x404, 0x408…; inst_pc matches; one instruction per cycle.
- inst_ready = 0, DEPTH = 4 → exactly 4 requests issued, then imem_req_valid 0. Releasing ready drains 4 instructions in order.
- 3-cycle memory latency, 3 in flight, redirect to 0x1002 → those 3 responses discarded, next request address 0x1000, first inst_pc 0x1000.
- Redirect, request fire and response in the same cycle → drop_cnt equals outstanding; no stale instruction reaches decode.
- resetl asserted low mid-stream → outputs zero immediately (async); restart fetches from the new startpc.
- With FETCH_PERF_CNT_EN: memory stalled 10 cycles while decode is ready → stall_cycles = 10.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch front end.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;
    localparam logic [PC_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, inst}; a pushed entry is visible at the head one cycle later.
// Flush beats push and pop; push when full and pop when empty are ignored.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       resetl,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_dat,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head_dat,
    output logic                       o_head_vld,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && (r_count != FULL);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge CLK) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_head_vld = (r_count != '0);
    assign o_count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch front end: in-order word requests, queued responses, redirect flush/drain.
// Requests stop while in-flight + queued reaches DEPTH; optional stall counter under FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [PC_W-1:0]   startpc,
    output logic              imem_req_valid,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [PC_W-1:0] r_fpc;
    logic [PC_W-1:0] r_rpc;
    logic [PC_W-1:0] w_redir_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_drop_calc;
    logic [CW-1:0]   w_drop_dec;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_inflight;
    logic            w_req_vld;
    logic            w_req_fire;
    logic            w_resp_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_head_vld;
    fetch_entry_t    w_head_dat;
    fetch_entry_t    w_push_dat;

    assign w_redir_pc  = redirect_pc & ~PC_W'(3);
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_req_vld   = (r_state == RUN) && (w_inflight < LIMIT);
    assign w_req_fire  = w_req_vld && imem_req_ready;
    assign w_resp_fire = imem_resp_valid;
    // Responses still owed after this edge; all of them are stale once a redirect lands.
    assign w_drop_calc = r_outstanding + CW'(w_req_fire) - CW'(w_resp_fire);
    assign w_drop_dec  = r_drop_cnt - CW'(w_resp_fire);
    assign w_push      = w_resp_fire && (r_state == RUN) && !redirect_valid;
    assign w_pop       = w_head_vld && inst_ready;
    assign w_push_dat  = '{pc: r_rpc, inst: imem_resp_data};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     w_next_state = RUN;
            DRAIN:   if (w_drop_dec == '0) w_next_state = RUN;
            default: w_next_state = BOOT;
        endcase
        if (redirect_valid) w_next_state = (w_drop_calc != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state       <= BOOT;
            r_fpc         <= '0;
            r_rpc         <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_next_state;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_fire);
            if (redirect_valid) begin
                r_fpc      <= w_redir_pc;
                r_rpc      <= w_redir_pc;
                r_drop_cnt <= w_drop_calc;
            end else if (r_state == BOOT) begin
                r_fpc <= startpc;
                r_rpc <= startpc;
            end else begin
                if (w_req_fire) r_fpc <= r_fpc + PC_INC;
                if (w_push)     r_rpc <= r_rpc + PC_INC;
                if (r_state == DRAIN && w_resp_fire) r_drop_cnt <= w_drop_dec;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK        (CLK),
        .resetl     (resetl),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head_dat (w_head_dat),
        .o_head_vld (w_head_vld),
        .o_count    (w_count)
    );

    assign imem_req_valid = w_req_vld;
    assign imem_req_addr  = r_fpc;
    assign inst_valid     = w_head_vld;
    assign inst_data      = w_head_vld ? w_head_dat.inst : '0;
    assign inst_pc        = w_head_vld ? w_head_dat.pc : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_stall_cycles <= '0;
        end else if ((r_state == RUN) && inst_ready && !w_head_vld && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
